// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like memory port between an instruction
// requester and a data requester. Only one transaction is outstanding at a time.
// Data wins by default. After STARVE_LIMIT consecutive data grants while the
// instruction port waits, the instruction port is granted.
module sram_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // instruction port
    input  logic        inst_req_i,
    input  logic        inst_wr_i,
    input  logic [1:0]  inst_size_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_wdata_i,
    input  logic [3:0]  inst_wstrb_i,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,
    output logic [31:0] inst_rdata_o,
    // data port
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_wstrb_i,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic [31:0] data_rdata_o,
    // memory port
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [1:0]  mem_size_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_addr_ok_i,
    input  logic        mem_data_ok_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;       // 1 = inst owns the bus, 0 = data
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       grant_inst;

    // State, owner and starvation counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state logic: arbitration in IDLE, handshake tracking in ADDR/WAIT
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        grant_inst   = inst_req_i && (!data_req_i || (starve_cnt_q == LIMIT));
        unique case (state_q)
            IDLE: begin
                if (inst_req_i || data_req_i) begin
                    state_d = ADDR;
                    owner_d = grant_inst;
                    if (grant_inst || !inst_req_i) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            ADDR: begin
                if (mem_addr_ok_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_data_ok_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory fields follow the owner; handshakes only reach the owner
    always_comb begin
        mem_req_o      = 1'b0;
        mem_wr_o       = owner_q ? inst_wr_i    : data_wr_i;
        mem_size_o     = owner_q ? inst_size_i  : data_size_i;
        mem_addr_o     = owner_q ? inst_addr_i  : data_addr_i;
        mem_wdata_o    = owner_q ? inst_wdata_i : data_wdata_i;
        mem_wstrb_o    = owner_q ? inst_wstrb_i : data_wstrb_i;
        inst_addr_ok_o = 1'b0;
        data_addr_ok_o = 1'b0;
        inst_data_ok_o = 1'b0;
        data_data_ok_o = 1'b0;
        unique case (state_q)
            ADDR: begin
                mem_req_o      = 1'b1;
                inst_addr_ok_o = owner_q  && mem_addr_ok_i;
                data_addr_ok_o = !owner_q && mem_addr_ok_i;
            end
            WAIT: begin
                inst_data_ok_o = owner_q  && mem_data_ok_i;
                data_data_ok_o = !owner_q && mem_data_ok_i;
            end
            default: ;
        endcase
    end

    assign inst_rdata_o = mem_rdata_i;
    assign data_rdata_o = mem_rdata_i;

endmodule

// File: doc/sram_bus_arbiter.md
SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data-port grants allowed while inst_req is pending; range 1..15.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 inst_req / inst_wr  in  1 each  instruction-port request valid; write flag.
REQ-005 inst_size  in  2; inst_addr  in  32; inst_wdata  in  32; inst_wstrb  in  4.
REQ-006 inst_addr_ok / inst_data_ok  out  1 each  instruction-port address accepted; response valid.
REQ-007 inst_rdata  out  32  instruction-port read data.
REQ-008 data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb  in  1/1/2/32/32/4  data-port request fields.
REQ-009 data_addr_ok / data_data_ok  out  1 each; data_rdata  out  32.
REQ-010 mem_req / mem_wr  out  1 each; mem_size  out  2; mem_addr  out  32; mem_wdata  out  32; mem_wstrb  out  4.
REQ-011 mem_addr_ok / mem_data_ok  in  1 each; mem_rdata  in  32.

Function
REQ-012 The block SHALL share one SRAM-like memory port between the inst and data requesters, with at most one transaction outstanding.
REQ-013 The FSM SHALL have exactly three states: IDLE, ADDR, and WAIT.
REQ-014 Requesters SHALL hold req and all request fields stable until their addr_ok is seen.
REQ-015 In IDLE with any request pending, the block SHALL latch the winner into owner, enter ADDR on the next edge, and drive mem_req=0 during IDLE.
REQ-016 Arbitration SHALL grant data over inst by default.
REQ-017 Arbitration SHALL grant inst when both requesters are pending and starve_cnt equals STARVE_LIMIT.
REQ-018 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on a data grant while inst_req=1.
REQ-019 starve_cnt SHALL clear on any inst grant.
REQ-020 starve_cnt SHALL clear on a data grant while inst_req=0.
REQ-021 In ADDR, the block SHALL drive mem_req=1 with mem_* fields passed combinationally from the owner's inputs.
REQ-022 In ADDR with mem_addr_ok=1, the block SHALL assert the owner's addr_ok in the same cycle and enter WAIT.
REQ-023 In ADDR with mem_addr_ok=0, the block SHALL remain in ADDR.
REQ-024 In WAIT, the block SHALL drive mem_req=0.
REQ-025 In WAIT with mem_data_ok=1, the block SHALL assert the owner's data_ok and drive the owner's rdata=mem_rdata in the same cycle, then return to IDLE.
REQ-026 Writes SHALL also wait for mem_data_ok before returning to IDLE.
REQ-027 The non-owner's addr_ok and data_ok SHALL be 0 at all times.
REQ-028 Both rdata outputs SHALL be driven with mem_rdata continuously; consumers qualify them with data_ok.
REQ-029 mem_data_ok in IDLE or ADDR SHALL be ignored, producing no requester data_ok and no state change.
REQ-030 mem_addr_ok outside ADDR SHALL be ignored.
REQ-031 A requester dropping req while in ADDR is illegal; the block SHALL still forward the owner's current inputs.
REQ-032 Minimum transaction latency SHALL be 3 cycles, request-seen to data_ok: IDLE, ADDR with same-cycle addr_ok, WAIT with same-cycle data_ok.
REQ-033 The next arbitration SHALL occur in the IDLE cycle following data_ok, with no back-to-back bypass.
REQ-034 When inst_req and data_req arrive in the same IDLE cycle, REQ-016 and REQ-017 SHALL decide the winner; the loser's req stays pending with no lost request.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL set state=IDLE, owner=data, and starve_cnt=0.
REQ-036 During and immediately after reset, all outputs SHALL be 0: mem_req, both addr_ok, and both data_ok.
REQ-037 Reset asserted in ADDR or WAIT SHALL abandon the transaction with no data_ok issued.
REQ-038 A mem_data_ok arriving after such a reset SHALL be ignored per REQ-029.

Verification
REQ-039 Single inst read: inst_req=1, addr=0x1C000000; mem_addr_ok in ADDR, mem_data_ok=1 with rdata=0x02800000 one cycle later -> inst_addr_ok=1 cycle 2, inst_data_ok=1 with inst_rdata=0x02800000 cycle 3, data_* outputs remain 0.
REQ-040 Simultaneous request: inst_req=data_req=1 in IDLE -> data granted first, mem_addr=data_addr; inst granted in the IDLE after data_data_ok.
REQ-041 Starvation: data_req held continuously, inst_req=1, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 inst grant, then starve_cnt=0.
REQ-042 Backpressure: mem_addr_ok=0 for 5 cycles in ADDR -> mem_req and fields stay stable and owner unchanged for 5 cycles, addr_ok on cycle 6.
REQ-043 Write: data_wr=1, wstrb=4'b0011, wdata=0xDEADBEEF -> mem_wr=1, mem_wstrb=4'b0011, mem_wdata=0xDEADBEEF; data_data_ok only on mem_data_ok.
REQ-044 Reset in WAIT, then mem_data_ok=1 next cycle -> no inst_data_ok or data_data_ok, state IDLE, mem_req=0.
